av_config_responder: RTL and testbench
======================================

Name: av_config_responder

Overview:
- I2C target (responder) for the two-wire audio/video configuration bus; the opposite end of the configuration master that drives SCLK and SDAT.
- Models a byte-addressed codec/decoder register bank, such as WM8731 (7'h1A) or ADV7180 (7'h20), for board loopback and system simulation.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain (low or released).
- Exposes a local read port and a per-byte write-event strobe.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address matched against the address byte.
- ADDR_W, 4, register-pointer width; register count is 2**ADDR_W.
- FILTER_LEN, 4, glitch-filter stability length in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock (>= 20x SCL rate).
- reset  in  1  asynchronous, active-high reset.
- scl_in  in  1  SCL pad input (asynchronous).
- sda_in  in  1  SDA pad input (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release the line.
- cfg_addr  in  ADDR_W  local read address.
- cfg_rdata  out  8  reg[cfg_addr], combinational.
- wr_strobe  out  1  one-cycle pulse when a byte is stored.
- wr_addr  out  ADDR_W  register written; valid with wr_strobe.
- wr_data  out  8  byte written; valid with wr_strobe.
- busy  out  1  high from an address-matched START until STOP.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, pointer=0, all registers=8'h00, state=IDLE.
- Input path: 2-flop synchronizer on SCL and SDA, then one registered copy for edge detection.
  - Edge/condition detection lags the pads by 3 clk.
- Bus conditions:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Both are detected in any state.
  - START -> ADDR (this is also a repeated start; the pointer is kept).
  - STOP -> IDLE, sda_oe=0, busy=0.
- Data sampling and driving:
  - Data is sampled on the SCL rising edge, MSB first, into an 8-bit shift register with a 3-bit bit counter.
  - sda_oe changes only on the detected SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If byte[7:1]==DEV_ADDR: on the following SCL fall, assert sda_oe (ACK) and set busy; go to ACK_A.
    - Otherwise go to IGNORE: sda_oe stays 0 until START/STOP.
  - ACK_A: release sda_oe on the next SCL fall.
    - R/W=0 -> PTR.
    - R/W=1 -> load reg[ptr] into the shift register and drive bit7 on that same fall -> RDATA.
  - PTR: shift 8 bits; pointer <= byte[ADDR_W-1:0] (upper bits ignored); ACK -> ACK_P -> WDATA.
  - WDATA: shift 8 bits.
    - On the 8th rising edge: reg[ptr] <= byte; pulse wr_strobe for one clk with wr_addr=ptr, wr_data=byte.
    - ACK -> ACK_W; pointer increments; stay in WDATA.
  - RDATA: drive sda_oe = ~bit on each SCL fall.
    - After the 8th bit, release on the fall -> MACK.
  - MACK: sample SDA on SCL rise.
    - 0 (ACK): pointer++, reload, continue RDATA.
    - 1 (NACK): -> IGNORE (released) until STOP/START.
- Pointer wraps modulo 2**ADDR_W (0xF -> 0x0 at the default).
- Simultaneous events: a START/STOP detected in the same clk as an SCL edge takes priority; no bit is shifted or stored.
- A STOP after a partial byte discards the partial byte; nothing is written and there is no strobe.
- Local cfg_rdata reads are never blocked.
- Reset mid-transfer releases SDA immediately (asynchronously).

Optional Feature:
- Macro AV_CONFIG_RESP_GLITCH_FILTER_EN.
- Defined: each synchronized line passes a stability filter; the output updates only after FILTER_LEN consecutive equal samples.
  - Pulses shorter than FILTER_LEN clk are ignored.
  - Detection latency becomes 3+FILTER_LEN clk.
- Undefined: synchronizer only; FILTER_LEN is unused; latency is 3 clk.

Decomposition:
- Shared package av_config_pkg:
  - state enum (IDLE, ADDR, ACK_A, PTR, ACK_P, WDATA, ACK_W, RDATA, MACK, IGNORE);
  - WM8731/ADV7180 address constants;
  - the ACK/NACK level constants.
- One natural sub-module: av_config_line_filter (synchronizer plus optional stability filter plus edge detect), instantiated for SCL and SDA.

Test Plan:
- Write: START, 0x34, 0x05, 0xA5, 0x3C, STOP -> ACK on all 4 bytes; reg[5]=0xA5, reg[6]=0x3C; two wr_strobe pulses (5/0xA5, 6/0x3C); busy low after STOP.
- Combined read: START, 0x34, 0x05, repeated START, 0x35, then master ACK then NACK -> SDA returns 0xA5 then 0x3C; after the NACK, sda_oe=0 until STOP.
- Wrong address: START, 0x40, 0x00, STOP -> sda_oe never asserted; no wr_strobe; busy stays 0; registers unchanged.
- Wrap and abort:
  - Write pointer 0x0F, then 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22.
  - Then START, 0x34, 0x02, 4 data bits, STOP -> reg[2] unchanged; no strobe.
- Reset: assert reset while driving read bit3 (sda_oe=1) -> sda_oe=0 the same clk; all cfg_rdata=0x00 afterwards; the next transaction works normally.
- With AV_CONFIG_RESP_GLITCH_FILTER_EN and FILTER_LEN=4: a 2-clk SCL low glitch mid-byte -> no extra bit shifted; the written byte is correct.

Source files
------------

// File: rtl/av_config_pkg.sv
// ============================================================================
// Module   : av_config_pkg
// Purpose  : Shared types and constants for the A/V configuration I2C responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package av_config_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ADDR   = 4'd1,
    ACK_A  = 4'd2,
    PTR    = 4'd3,
    ACK_P  = 4'd4,
    WDATA  = 4'd5,
    ACK_W  = 4'd6,
    RDATA  = 4'd7,
    MACK   = 4'd8,
    IGNORE = 4'd9
  } state_t;

  localparam logic [6:0] c_WM8731_ADDR  = 7'h1A;
  localparam logic [6:0] c_ADV7180_ADDR = 7'h20;

  // SDA bus levels for the acknowledge bit
  localparam logic c_ACK  = 1'b0;
  localparam logic c_NACK = 1'b1;

endpackage

`default_nettype wire

// File: rtl/av_config_line_filter.sv
// ============================================================================
// Module   : av_config_line_filter
// Purpose  : Pad synchronizer, optional stability filter (macro
//            AV_CONFIG_RESP_GLITCH_FILTER_EN) and edge detector for SCL/SDA.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module av_config_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  // Idle bus level is high, so reset to 1 to avoid phantom edges.
  logic r_s1, r_s2, r_prev;
  logic w_clean;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_line;
      r_s2 <= r_s1;
    end
  end

`ifdef AV_CONFIG_RESP_GLITCH_FILTER_EN
  localparam int c_CNT_W = $clog2(FILTER_LEN + 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_filt;

  // Follow the line only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_filt <= 1'b1;
    end else if (r_s2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == c_CNT_W'(FILTER_LEN - 1)) begin
      r_cnt  <= '0;
      r_filt <= r_s2;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign w_clean = r_filt;
`else
  assign w_clean = r_s2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 1'b1;
    else       r_prev <= w_clean;
  end

  assign o_level = w_clean;
  assign o_rise  = w_clean & ~r_prev;
  assign o_fall  = ~w_clean & r_prev;

endmodule

`default_nettype wire

// File: rtl/av_config_responder.sv
// ============================================================================
// Module   : av_config_responder
// Purpose  : I2C target modelling a byte-addressed codec register bank with a
//            local read port; glitch filter via AV_CONFIG_RESP_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module av_config_responder
  import av_config_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = c_WM8731_ADDR,
  parameter int         ADDR_W     = 4,
  parameter int         FILTER_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [ADDR_W-1:0] cfg_addr,
  output logic [7:0]        cfg_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int c_NREG = 2 ** ADDR_W;

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;

  av_config_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk    (clk),
    .reset  (reset),
    .i_line (scl_in),
    .o_level(w_scl_lvl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  av_config_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk    (clk),
    .reset  (reset),
    .i_line (sda_in),
    .o_level(w_sda_lvl),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  wire w_start = w_sda_fall & w_scl_lvl;
  wire w_stop  = w_sda_rise & w_scl_lvl;

  state_t            r_state, w_state;
  logic [7:0]        r_shift, w_shift;
  logic [2:0]        r_cnt, w_cnt;
  logic              r_done, w_done;
  logic              r_rw, w_rw;
  logic              r_mack, w_mack;
  logic [ADDR_W-1:0] r_ptr, w_ptr;
  logic              r_sda_oe, w_sda_oe;
  logic              r_busy, w_busy;
  logic              r_strobe, w_strobe;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr;
  logic [7:0]        r_wr_data, w_wr_data;
  logic              w_we;
  logic [7:0]        r_regs [c_NREG];

  wire [7:0]        w_byte     = {r_shift[6:0], w_sda_lvl};
  wire [ADDR_W-1:0] w_ptr_inc  = r_ptr + ADDR_W'(1);
  wire [7:0]        w_rd_cur   = r_regs[r_ptr];
  wire [7:0]        w_rd_next  = r_regs[w_ptr_inc];

  always_comb begin
    w_state   = r_state;
    w_shift   = r_shift;
    w_cnt     = r_cnt;
    w_done    = r_done;
    w_rw      = r_rw;
    w_mack    = r_mack;
    w_ptr     = r_ptr;
    w_sda_oe  = r_sda_oe;
    w_busy    = r_busy;
    w_strobe  = 1'b0;
    w_wr_addr = r_wr_addr;
    w_wr_data = r_wr_data;
    w_we      = 1'b0;

    // Bus conditions pre-empt any SCL edge seen in the same cycle.
    if (w_stop) begin
      w_state  = IDLE;
      w_sda_oe = 1'b0;
      w_busy   = 1'b0;
      w_done   = 1'b0;
      w_cnt    = 3'd0;
    end else if (w_start) begin
      w_state  = ADDR;
      w_sda_oe = 1'b0;
      w_done   = 1'b0;
      w_cnt    = 3'd0;
    end else begin
      case (r_state)
        ADDR, PTR, WDATA: begin
          if (w_scl_rise && !r_done) begin
            w_shift = w_byte;
            w_cnt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_done = 1'b1;
              if (r_state == ADDR) begin
                w_rw = w_sda_lvl;
              end else if (r_state == PTR) begin
                w_ptr = w_byte[ADDR_W-1:0];
              end else begin
                w_we      = 1'b1;
                w_strobe  = 1'b1;
                w_wr_addr = r_ptr;
                w_wr_data = w_byte;
              end
            end
          end else if (w_scl_fall && r_done) begin
            w_done = 1'b0;
            if (r_state == ADDR && r_shift[7:1] != DEV_ADDR) begin
              w_state = IGNORE;
            end else begin
              w_sda_oe = ~c_ACK;
              case (r_state)
                ADDR: begin
                  w_state = ACK_A;
                  w_busy  = 1'b1;
                end
                PTR:     w_state = ACK_P;
                default: w_state = ACK_W;
              endcase
            end
          end
        end
        ACK_A: begin
          if (w_scl_fall) begin
            w_cnt = 3'd0;
            if (r_rw) begin
              w_shift  = w_rd_cur;
              w_sda_oe = ~w_rd_cur[7];
              w_state  = RDATA;
            end else begin
              w_sda_oe = 1'b0;
              w_state  = PTR;
            end
          end
        end
        ACK_P: begin
          if (w_scl_fall) begin
            w_sda_oe = 1'b0;
            w_cnt    = 3'd0;
            w_state  = WDATA;
          end
        end
        ACK_W: begin
          if (w_scl_fall) begin
            w_sda_oe = 1'b0;
            w_cnt    = 3'd0;
            w_ptr    = w_ptr_inc;
            w_state  = WDATA;
          end
        end
        RDATA: begin
          if (w_scl_rise) begin
            w_cnt = r_cnt + 3'd1;
            if (r_cnt == 3'd7) w_done = 1'b1;
          end else if (w_scl_fall) begin
            if (r_done) begin
              w_done   = 1'b0;
              w_sda_oe = 1'b0;
              w_state  = MACK;
            end else begin
              w_shift  = {r_shift[6:0], 1'b0};
              w_sda_oe = ~r_shift[6];
            end
          end
        end
        MACK: begin
          if (w_scl_rise) begin
            w_mack = w_sda_lvl;
            w_done = 1'b1;
          end else if (w_scl_fall && r_done) begin
            w_done = 1'b0;
            if (r_mack == c_ACK) begin
              w_ptr    = w_ptr_inc;
              w_shift  = w_rd_next;
              w_sda_oe = ~w_rd_next[7];
              w_cnt    = 3'd0;
              w_state  = RDATA;
            end else begin
              w_state = IGNORE;
            end
          end
        end
        IDLE, IGNORE: ;
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= 8'h00;
      r_cnt     <= 3'd0;
      r_done    <= 1'b0;
      r_rw      <= 1'b0;
      r_mack    <= c_NACK;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_strobe  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 8'h00;
    end else begin
      r_state   <= w_state;
      r_shift   <= w_shift;
      r_cnt     <= w_cnt;
      r_done    <= w_done;
      r_rw      <= w_rw;
      r_mack    <= w_mack;
      r_ptr     <= w_ptr;
      r_sda_oe  <= w_sda_oe;
      r_busy    <= w_busy;
      r_strobe  <= w_strobe;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_NREG; i++) r_regs[i] <= 8'h00;
    end else if (w_we) begin
      r_regs[r_ptr] <= w_byte;
    end
  end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign wr_strobe = r_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign cfg_rdata = r_regs[cfg_addr];

endmodule

`default_nettype wire

// File: tb/tb_av_config_responder.sv
// ============================================================================
// Module   : tb_av_config_responder
// Purpose  : Directed self-checking bench acting as the I2C configuration
//            master against av_config_responder (WM8731 address 7'h1A).
// Revision : 1.1 - task-based checking and watchdog
// ============================================================================
`default_nettype none

module tb_av_config_responder;

    localparam int c_Q       = 8;
    localparam int c_TIMEOUT = 200000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [3:0] cfg_addr = 4'd0;
    logic [7:0] cfg_rdata;
    logic       sda_oe, wr_strobe, busy;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    wire        sda_bus = m_sda & ~sda_oe;

    int n_cmp = 0;
    int n_fail = 0;
    int strobe_cnt = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;
    logic [3:0] q_addr [$];
    logic [7:0] q_data [$];

    always #5 clk = ~clk;

    av_config_responder dut (
        .clk      (clk),
        .reset    (rst),
        .scl_in   (m_scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .cfg_addr (cfg_addr),
        .cfg_rdata(cfg_rdata),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt++;
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
        end
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (c_TIMEOUT) @(negedge clk);
        n_fail++;
        $error("FAIL timeout: wait expired after %0d clk cycles", c_TIMEOUT);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    task automatic step();
        repeat (c_Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; step();
        m_scl = 1'b1; step();
        m_sda = 1'b0; step();
        m_scl = 1'b0; step();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; step();
        m_scl = 1'b1; step();
        m_sda = 1'b1; step();
        step();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; step();
        m_scl = 1'b1; step(); step();
        m_scl = 1'b0; step();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; step();
        m_scl = 1'b1; step();
        b = sda_bus; step();
        m_scl = 1'b0; step();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic bv;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bv);
            d[i] = bv;
        end
        write_bit(mack);
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        cfg_addr = a;
        #1;
        chk(tag, cfg_rdata, exp);
    endtask

`ifdef AV_CONFIG_RESP_GLITCH_FILTER_EN
    task automatic write_bit_glitch(input logic b);
        m_sda = b; step();
        m_scl = 1'b1; step();
        m_scl = 1'b0; repeat (2) @(negedge clk);
        m_scl = 1'b1; step();
        m_scl = 1'b0; step();
    endtask
`endif

    initial begin
        logic a0, a1, a2, a3;
        logic [7:0] d0, d1;
        int snap_s, snap_oe, snap_b;

        repeat (4) @(negedge clk);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_wr_addr", wr_addr, 4'h0);
        chk("rst_wr_data", wr_data, 8'h00);
        chk_reg("rst_reg5", 4'd5, 8'h00);
        rst = 1'b0;
        step();

        i2c_start();
        send_byte(8'h34, a0);
        chk("wr_busy_after_addr", busy, 1'b1);
        send_byte(8'h05, a1);
        send_byte(8'hA5, a2);
        send_byte(8'h3C, a3);
        i2c_stop();
        chk("wr_ack_addr", a0, 1'b0);
        chk("wr_ack_ptr", a1, 1'b0);
        chk("wr_ack_d0", a2, 1'b0);
        chk("wr_ack_d1", a3, 1'b0);
        chk("wr_busy_after_stop", busy, 1'b0);
        chk("wr_strobe_cnt", strobe_cnt, 2);
        chk("wr_strobe0_addr", q_addr[0], 4'h5);
        chk("wr_strobe0_data", q_data[0], 8'hA5);
        chk("wr_strobe1_addr", q_addr[1], 4'h6);
        chk("wr_strobe1_data", q_data[1], 8'h3C);
        chk_reg("wr_reg5", 4'd5, 8'hA5);
        chk_reg("wr_reg6", 4'd6, 8'h3C);

        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h05, a1);
        i2c_start();
        send_byte(8'h35, a2);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        chk("rd_ack_addr_r", a2, 1'b0);
        chk("rd_byte0", d0, 8'hA5);
        chk("rd_byte1", d1, 8'h3C);
        snap_oe = oe_cnt;
        write_bit(1'b1);
        write_bit(1'b1);
        chk("rd_released_after_nack", oe_cnt - snap_oe, 0);
        i2c_stop();
        chk("rd_busy_after_stop", busy, 1'b0);

        snap_s = strobe_cnt; snap_oe = oe_cnt; snap_b = busy_cnt;
        i2c_start();
        send_byte(8'h40, a0);
        send_byte(8'h00, a1);
        i2c_stop();
        chk("na_ack_addr", a0, 1'b1);
        chk("na_ack_data", a1, 1'b1);
        chk("na_no_drive", oe_cnt - snap_oe, 0);
        chk("na_no_busy", busy_cnt - snap_b, 0);
        chk("na_no_strobe", strobe_cnt - snap_s, 0);
        chk_reg("na_reg0", 4'd0, 8'h00);
        chk_reg("na_reg5", 4'd5, 8'hA5);

        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h0F, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a3);
        i2c_stop();
        chk("wrap_ack_d1", a3, 1'b0);
        chk_reg("wrap_reg15", 4'd15, 8'h11);
        chk_reg("wrap_reg0", 4'd0, 8'h22);
        chk("wrap_strobe2_addr", q_addr[2], 4'hF);
        chk("wrap_strobe3_addr", q_addr[3], 4'h0);

        snap_s = strobe_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h02, a1);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        chk_reg("abort_reg2", 4'd2, 8'h00);
        chk("abort_no_strobe", strobe_cnt - snap_s, 0);

        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h05, a1);
        i2c_start();
        send_byte(8'h35, a2);
        for (int i = 0; i < 4; i++) read_bit(a3);
        chk("rst_mid_pre_drive", sda_oe, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_release", sda_oe, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_sda = 1'b1; step();
        m_scl = 1'b1; step();
        for (int i = 0; i < 16; i++) chk_reg("rst_mid_regs", 4'(i), 8'h00);
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h03, a1);
        send_byte(8'h5A, a2);
        i2c_stop();
        chk("post_rst_ack", a2, 1'b0);
        chk_reg("post_rst_reg3", 4'd3, 8'h5A);
        chk("post_rst_strobe_data", q_data[4], 8'h5A);

`ifdef AV_CONFIG_RESP_GLITCH_FILTER_EN
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h07, a1);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b0);
        write_bit_glitch(1'b1);
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
        read_bit(a2);
        i2c_stop();
        chk("glitch_ack", a2, 1'b0);
        chk_reg("glitch_reg7", 4'd7, 8'h96);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
